// File: rtl/accel_spi_pkg.sv
// Shared constants for the SPI accelerometer responder: command bytes,
// register addresses, fixed read-only values and the FSM state encoding.
package accel_spi_pkg;

    // Command bytes understood in the first byte of a frame
    localparam logic [7:0] CMD_WRITE   = 8'h0A;
    localparam logic [7:0] CMD_READ    = 8'h0B;

    // Register map addresses with fixed or live content
    localparam logic [7:0] ADDR_DEVID  = 8'h00;
    localparam logic [7:0] ADDR_ID1    = 8'h01;
    localparam logic [7:0] ADDR_ID2    = 8'h02;
    localparam logic [7:0] ADDR_XDATA  = 8'h08;
    localparam logic [7:0] ADDR_YDATA  = 8'h09;
    localparam logic [7:0] ADDR_ZDATA  = 8'h0A;

    // Fixed read-only identification values
    localparam logic [7:0] ID1_VALUE   = 8'h1D;
    localparam logic [7:0] ID2_VALUE   = 8'hF2;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CMD      = 3'd1;
    localparam logic [2:0] ST_ADDR     = 3'd2;
    localparam logic [2:0] ST_WDATA    = 3'd3;
    localparam logic [2:0] ST_RDATA    = 3'd4;
    localparam logic [2:0] ST_IGNORE   = 3'd5;

    // True for addresses whose content is not backed by RW storage
    function automatic logic is_fixed_addr(input logic [7:0] addr);
        return (addr == ADDR_DEVID) || (addr == ADDR_ID1)   || (addr == ADDR_ID2) ||
               (addr == ADDR_XDATA) || (addr == ADDR_YDATA) || (addr == ADDR_ZDATA);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous input with single-cycle
// rising/falling edge pulses derived from the synchronised level.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;
    logic prev_q;
    logic prev_d;

    // Next-state of the synchroniser chain and the edge-history flop
    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchroniser and history registers, all reset to the chosen idle value
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 slave emulating the accelerometer register interface.
// Frames: command byte (0x0A write / 0x0B read), address byte, data bytes.
// Optional feature macro SPI_ACCEL_AUTO_INC_EN: when defined, the address
// advances after each data byte for burst access; otherwise it stays fixed.
module spi_accel_responder
    import accel_spi_pkg::*;
#(
    parameter int         NUM_REGS = 48,
    parameter logic [7:0] DEVID    = 8'hAD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic [7:0] x_data,
    input  logic [7:0] y_data,
    input  logic [7:0] z_data,
    output logic       miso,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

    logic cs_s;
    logic cs_rise_s;
    logic cs_fall_s;
    logic sclk_s;
    logic sclk_rise_s;
    logic sclk_fall_s;
    logic mosi_s;
    logic mosi_rise_s;
    logic mosi_fall_s;
    logic unused_s;

    // cs_n resets to "low" so that a transaction can only begin after
    // cs_n has actually been observed high following reset.
    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_cs (
        .clk(clk), .reset(reset), .d_in(cs_n),
        .level(cs_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d_in(sclk),
        .level(sclk_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d_in(mosi),
        .level(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
    );

    assign unused_s = sclk_s ^ mosi_rise_s ^ mosi_fall_s;

    logic [2:0] state_q,     state_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [6:0] shift_in_q,  shift_in_d;
    logic       is_write_q,  is_write_d;
    logic [7:0] addr_q,      addr_d;
    logic [6:0] rd_shift_q,  rd_shift_d;
    logic       miso_q,      miso_d;
    logic       busy_q,      busy_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [7:0] wr_addr_q,   wr_addr_d;
    logic [7:0] wr_data_q,   wr_data_d;
    logic [7:0] x_snap_q,    x_snap_d;
    logic [7:0] y_snap_q,    y_snap_d;
    logic [7:0] z_snap_q,    z_snap_d;
    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] regs_d [NUM_REGS];

    logic [7:0] byte_in_s;
    logic       byte_done_s;
    logic [7:0] addr_next_s;
    logic [7:0] rd_addr_s;
    logic [7:0] rd_value_s;
    logic       wr_ok_s;

    assign byte_in_s   = {shift_in_q, mosi_s};
    assign byte_done_s = sclk_rise_s && (bit_cnt_q == 3'd7);
    assign wr_ok_s     = !is_fixed_addr(addr_q) && ({1'b0, addr_q} < NUM_REGS_W);

`ifdef SPI_ACCEL_AUTO_INC_EN
    assign addr_next_s = addr_q + 8'd1;
`else
    assign addr_next_s = addr_q;
`endif

    // Read address: the byte just received in ADDR, or the following address in RDATA
    always_comb begin
        if (state_q == ST_RDATA) begin
            rd_addr_s = addr_next_s;
        end else begin
            rd_addr_s = byte_in_s;
        end
    end

    // Register map read decode; addresses at or above NUM_REGS read as zero
    always_comb begin
        rd_value_s = 8'h00;
        case (rd_addr_s)
            ADDR_DEVID: rd_value_s = DEVID;
            ADDR_ID1:   rd_value_s = ID1_VALUE;
            ADDR_ID2:   rd_value_s = ID2_VALUE;
            ADDR_XDATA: rd_value_s = x_snap_q;
            ADDR_YDATA: rd_value_s = y_snap_q;
            ADDR_ZDATA: rd_value_s = z_snap_q;
            default: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    rd_value_s = (rd_addr_s == 8'(i)) ? regs_q[i] : rd_value_s;
                end
            end
        endcase
    end

    // Protocol FSM, bit/byte assembly, read shifting and write commit
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        rd_shift_d  = rd_shift_q;
        miso_d      = miso_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        x_snap_d    = x_snap_q;
        y_snap_d    = y_snap_q;
        z_snap_d    = z_snap_q;

        if (cs_rise_s) begin
            // End of frame: any partial byte is simply dropped
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end else if (cs_fall_s) begin
            // Start of frame: snapshot the sample so a burst stays coherent
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
            x_snap_d  = x_data;
            y_snap_d  = y_data;
            z_snap_d  = z_data;
        end else begin
            if (sclk_rise_s && (state_q != ST_IDLE)) begin
                shift_in_d = byte_in_s[6:0];
                bit_cnt_d  = bit_cnt_q + 3'd1;
            end else begin
                bit_cnt_d  = bit_cnt_q;
            end

            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                end
                ST_CMD: begin
                    if (byte_done_s) begin
                        case (byte_in_s)
                            CMD_WRITE: begin
                                is_write_d = 1'b1;
                                state_d    = ST_ADDR;
                            end
                            CMD_READ: begin
                                is_write_d = 1'b0;
                                state_d    = ST_ADDR;
                            end
                            default: begin
                                state_d    = ST_IGNORE;
                            end
                        endcase
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (byte_done_s) begin
                        addr_d = byte_in_s;
                        if (is_write_q) begin
                            state_d = ST_WDATA;
                        end else begin
                            state_d    = ST_RDATA;
                            rd_shift_d = rd_value_s[6:0];
                            miso_d     = rd_value_s[7];
                        end
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_WDATA: begin
                    if (byte_done_s) begin
                        wr_strobe_d = wr_ok_s;
                        addr_d      = addr_next_s;
                        if (wr_ok_s) begin
                            wr_addr_d = addr_q;
                            wr_data_d = byte_in_s;
                        end else begin
                            wr_addr_d = wr_addr_q;
                        end
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (byte_done_s) begin
                        // Preload the next byte so bit 7 is ready before the next rising edge
                        addr_d     = addr_next_s;
                        rd_shift_d = rd_value_s[6:0];
                        miso_d     = rd_value_s[7];
                    end else if (sclk_fall_s && (bit_cnt_q != 3'd0)) begin
                        // Falling edge at a byte boundary is skipped so bit 7 is not lost
                        miso_d     = rd_shift_q[6];
                        rd_shift_d = {rd_shift_q[5:0], 1'b0};
                    end else begin
                        miso_d     = miso_q;
                    end
                end
                ST_IGNORE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end

        busy_d = !cs_s && (state_d != ST_IDLE);
    end

    // RW storage next value: the committed write lands in the same cycle as wr_strobe
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = (wr_strobe_d && (wr_addr_d == 8'(i))) ? wr_data_d : regs_q[i];
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_in_q  <= 7'd0;
            is_write_q  <= 1'b0;
            addr_q      <= 8'h00;
            rd_shift_q  <= 7'd0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            x_snap_q    <= 8'h00;
            y_snap_q    <= 8'h00;
            z_snap_q    <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            rd_shift_q  <= rd_shift_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            x_snap_q    <= x_snap_d;
            y_snap_q    <= y_snap_d;
            z_snap_q    <= z_snap_d;
            regs_q      <= regs_d;
        end
    end

    assign miso      = miso_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: doc/spi_accel_responder.md
Name: spi_accel_responder

Overview:
SPI mode-0 slave that models the accelerometer's side of the link driven by the team's SPI master (CS/SCLK/SDO out, SDI in). It runs off the system clock and oversamples CS, SCLK and MOSI. It decodes the 3-byte read/write command protocol and serves a small register map that includes live X/Y/Z sample registers. It lets the on-board master and state controller be exercised in simulation and on hardware without the physical sensor.

Parameters:
NUM_REGS, 48, number of implemented byte addresses (0x00..NUM_REGS-1); must be 16..256.
DEVID, 8'hAD, value returned at address 0x00.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cs_n  in  1  chip select from master, active low
sclk  in  1  serial clock from master, idles low
mosi  in  1  serial data from master, MSB first
x_data  in  8  current X sample, signed
y_data  in  8  current Y sample, signed
z_data  in  8  current Z sample, signed
miso  out  1  serial data to master; driven 0 when idle
wr_strobe  out  1  one-cycle pulse on each committed register write
wr_addr  out  8  address of committed write, valid with wr_strobe
wr_data  out  8  data of committed write, valid with wr_strobe
busy  out  1  high while cs_n is synchronised low

Behaviour:
- Reset values: miso=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, state=IDLE, RW registers=0x00. Reset mid-transaction aborts it; a new transaction starts only after cs_n is seen high.
- cs_n, sclk and mosi pass through 2-flop synchronisers. Edges are detected on the synchronised copies. sclk frequency must be <= clk/8.
- Register map: 0x00=DEVID (RO), 0x01=0x1D (RO), 0x02=0xF2 (RO), 0x08=X (RO), 0x09=Y (RO), 0x0A=Z (RO). All other addresses below NUM_REGS are RW storage. Reads at or above NUM_REGS return 0x00. Writes to RO or out-of-range addresses are dropped, with no wr_strobe.
- X/Y/Z are snapshotted on the synchronised cs_n falling edge, so a burst always returns one coherent sample.
- FSM states: IDLE -> CMD on cs_n falling edge.
- CMD -> ADDR after 8 sclk rising edges if the command byte is 0x0A (write) or 0x0B (read); any other byte -> IGNORE.
- ADDR -> WDATA or RDATA after 8 more rising edges.
- IGNORE holds miso=0 until cs_n rises.
- Any state returns to IDLE on the cs_n rising edge.
- Bit counter (3 bits) resets on every byte boundary and on cs_n falling edge. mosi is sampled on sclk rising edges.
- Read path: on the 8th rising edge of ADDR (and of each later RDATA byte), the read-shift register loads reg[addr] in the same cycle and miso immediately presents bit 7. Each sclk falling edge then shifts miso to the next bit.
- Write path: on the 8th rising edge of each WDATA byte, wr_strobe pulses one cycle later and the RW register updates in that same cycle.
- A cs_n rise mid-byte discards the partial byte. No write is committed and nothing is corrupted.
- Address pointer is 8 bits and wraps 0xFF -> 0x00.

Optional Feature:
Macro SPI_ACCEL_AUTO_INC_EN.
- Defined: after each completed data byte the address increments by 1, giving burst read/write across consecutive registers.
- Undefined: the address stays fixed for the whole transaction. Repeated read bytes return the same register and repeated write bytes rewrite the same address, with one wr_strobe per byte.

Decomposition:
- Package accel_spi_pkg holds:
  - command constants CMD_WRITE=8'h0A and CMD_READ=8'h0B;
  - register address constants (DEVID, XDATA, YDATA, ZDATA) and the fixed RO values;
  - the FSM state encoding (IDLE, CMD, ADDR, WDATA, RDATA, IGNORE).
- One sub-module, spi_sync_edge: 2-flop synchroniser plus rising/falling-edge pulse outputs. Instantiated three times (cs_n, sclk, mosi).

Test Plan:
- Read 0x0B,0x00 then one dummy byte, with sclk=clk/8 -> third byte on miso = 0xAD; busy high for the frame; no wr_strobe.
- Write 0x0A,0x20,0x5C then read 0x0B,0x20 -> wr_strobe once with wr_addr=0x20, wr_data=0x5C; readback = 0x5C.
- x/y/z=0x12/0xF0/0x7F; burst read from 0x08 with 3 data bytes; change x_data mid-frame -> 0x12,0xF0,0x7F with AUTO_INC; 0x12,0x12,0x12 without.
- Command byte 0x55 followed by 16 clocks -> miso stays 0, no wr_strobe, FSM IDLE after cs_n rises.
- Write 0x0A,0x21 then 4 bits of data, cs_n rises -> no wr_strobe; reg 0x21 keeps its old value; next full transaction decodes correctly.
- Assert reset during RDATA -> miso=0, busy=0 next cycle; RW registers read back 0x00 afterwards; write to 0x08 produces no strobe and X is unchanged.
